// File: rtl/rob_commit.sv
// In-order reorder buffer feeding the register-file write-back port.
// Entries are allocated at the tail, completed from the CDB in any order,
// and retired strictly from the head. Register writes are emitted as a
// one-cycle rob_we strobe with index/data already stable one cycle earlier.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the head entry to be done; non-writers pop here
// SETUP  | rob_windex/rob_wdata loaded, rob_we rises on the next edge
// STROBE | rob_we high for this cycle; head pops at the end of it

module rob_commit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [4:0]       issue_dest,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             flush,
  output logic             rob_we,
  output logic [31:0]      rob_wdata,
  output logic [4:0]       rob_windex,
  output logic [TAG_W:0]   rob_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_wr;
  logic [4:0]       ent_dest [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  state_t           state;

  logic             issue_accept;
  logic             op_writes;
  logic             cdb_hit;
  logic             head_ready;
  logic [TAG_W-1:0] head_nxt;
  logic             nxt_ready;
  logic             pop;
  logic [TAG_W:0]   count_nxt;

  assign issue_ready  = (count != FULL_CNT);
  assign issue_tag    = tail;
  assign rob_count    = count;
  assign issue_accept = issue_valid && issue_ready;

  // sw and bne retire without touching the register file
  assign op_writes = (issue_op != 6'b000111) && (issue_op != 6'b001000);

  // The allocate guard is belt-and-braces: a free tail slot is never valid.
  assign cdb_hit = cdb_valid && ent_valid[cdb_tag] && !ent_done[cdb_tag]
                   && !(issue_accept && (cdb_tag == tail));

  assign head_ready = ent_valid[head] && ent_done[head];
  assign head_nxt   = head + PTR_ONE;
  assign nxt_ready  = ent_valid[head_nxt] && ent_done[head_nxt] && ent_wr[head_nxt];

  // A head pops either as a silent retire from IDLE or at the end of its strobe
  assign pop = !flush && (((state == IDLE) && head_ready && !ent_wr[head])
                          || (state == STROBE));

  // Occupancy update for simultaneous allocate and retire
  always_comb begin
    count_nxt = count;
    case ({issue_accept, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Entry storage: allocate at tail, capture CDB results, free popped head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_done  <= '0;
      ent_wr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_dest[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
      end
      if (issue_accept) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        ent_wr[tail]    <= op_writes;
        ent_dest[tail]  <= issue_dest;
      end
      if (cdb_hit) begin
        ent_done[cdb_tag] <= 1'b1;
        ent_data[cdb_tag] <= cdb_data;
      end
    end
  end

  // Head/tail pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head_nxt;
      end
      if (issue_accept) begin
        tail <= tail + PTR_ONE;
      end
      count <= count_nxt;
    end
  end

  // Commit FSM with registered write-back outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rob_we     <= 1'b0;
      rob_wdata  <= '0;
      rob_windex <= '0;
    end else if (flush) begin
      state  <= IDLE;
      rob_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rob_we <= 1'b0;
          if (head_ready && ent_wr[head]) begin
            rob_windex <= ent_dest[head];
            rob_wdata  <= ent_data[head];
            state      <= SETUP;
          end
        end
        SETUP: begin
          rob_we <= 1'b1;
          state  <= STROBE;
        end
        STROBE: begin
          rob_we <= 1'b0;
          if (nxt_ready) begin
            rob_windex <= ent_dest[head_nxt];
            rob_wdata  <= ent_data[head_nxt];
            state      <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          rob_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus a randomized run, all
// checked cycle by cycle against a program-order queue model.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [5:0]  issue_op = '0;
  logic [4:0]  issue_dest = '0;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        flush = 1'b0;
  logic        rob_we;
  logic [31:0] rob_wdata;
  logic [4:0]  rob_windex;
  logic [3:0]  rob_count;

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .rob_we(rob_we), .rob_wdata(rob_wdata), .rob_windex(rob_windex),
    .rob_count(rob_count)
  );

  typedef struct {
    int          tag;
    bit          wr;
    int          dest;
    logic [31:0] data;
    bit          done;
  } ent_t;

  // Reference: program-order queue plus the write-back port timing.
  // m_ph: 0 no write in flight, 1 operands presented, 2 strobe cycle.
  ent_t        q[$];
  int          m_tail;
  int          m_ph;
  bit          m_we;
  logic [31:0] m_wdata;
  logic [4:0]  m_windex;

  int          n_checks = 0;
  int          n_errors = 0;
  int          strobes = 0;
  logic [31:0] last_wdata = '0;
  logic [4:0]  last_windex = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_tail = 0; m_ph = 0; m_we = 0; m_wdata = '0; m_windex = '0;
  endfunction

  function automatic void load_head();
    m_windex = 5'(q[0].dest);
    m_wdata  = q[0].data;
    m_ph     = 1;
  endfunction

  function automatic void model_step();
    bit we_n;
    bit ready;
    ent_t e;
    we_n  = 1'b0;
    ready = (q.size() != 8);
    if (flush) begin
      q.delete(); m_tail = 0; m_ph = 0; m_we = 0;
      return;
    end
    case (m_ph)
      1: begin we_n = 1'b1; m_ph = 2; end
      2: begin
        void'(q.pop_front());
        m_ph = 0;
        if (q.size() > 0 && q[0].done && q[0].wr) load_head();
      end
      default: begin
        if (q.size() > 0 && q[0].done) begin
          if (q[0].wr) load_head();
          else void'(q.pop_front());
        end
      end
    endcase
    m_we = we_n;
    if (cdb_valid) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i].tag == int'(cdb_tag) && !q[i].done) begin
          q[i].done = 1'b1;
          q[i].data = cdb_data;
        end
    end
    if (issue_valid && ready) begin
      e.tag  = m_tail;
      e.wr   = !(issue_op == 6'd7 || issue_op == 6'd8);
      e.dest = int'(issue_dest);
      e.data = '0;
      e.done = 1'b0;
      q.push_back(e);
      m_tail = (m_tail + 1) % 8;
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("rob_we", 32'(rob_we), 32'(m_we));
    chk("rob_count", 32'(rob_count), 32'(q.size()));
    chk("issue_ready", 32'(issue_ready), 32'(q.size() != 8));
    chk("issue_tag", 32'(issue_tag), 32'(m_tail));
    chk("rob_windex", 32'(rob_windex), 32'(m_windex));
    chk("rob_wdata", rob_wdata, m_wdata);
    if (rob_we) begin
      strobes++;
      last_wdata  = rob_wdata;
      last_windex = rob_windex;
    end
  endtask

  task automatic clr_in();
    issue_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] dest);
    issue_valid = 1'b1; issue_op = op; issue_dest = dest;
    cyc();
    clr_in();
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    cyc();
    clr_in();
  endtask

  task automatic idle(input int n);
    clr_in();
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int s0;
    int guard;
    model_reset();
    #3;
    chk("reset_we", 32'(rob_we), 32'd0);
    chk("reset_count", 32'(rob_count), 32'd0);
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_wdata", rob_wdata, 32'd0);
    #9 rst_n = 1'b1;

    // single add write-back
    s0 = strobes;
    issue(6'd0, 5'd5);
    cdb(3'd0, 32'h0000_00AA);
    idle(5);
    chk("single_strobes", 32'(strobes - s0), 32'd1);
    chk("single_index", 32'(last_windex), 32'd5);
    chk("single_data", last_wdata, 32'hAA);

    // out-of-order completion, in-order retirement
    flush = 1'b1; cyc(); clr_in();
    s0 = strobes;
    issue(6'd0, 5'd1);
    issue(6'd2, 5'd2);
    issue(6'd3, 5'd3);
    cdb(3'd2, 32'h30);
    cdb(3'd1, 32'h20);
    cdb(3'd0, 32'h10);
    idle(8);
    chk("ooo_strobes", 32'(strobes - s0), 32'd3);
    chk("ooo_last_index", 32'(last_windex), 32'd3);
    chk("ooo_last_data", last_wdata, 32'h30);

    // fill, overflow attempt, partial retire, wrap-around reuse
    flush = 1'b1; cyc(); clr_in();
    for (int i = 0; i < 8; i++) issue(6'd1, 5'(i + 8));
    chk("full_ready", 32'(issue_ready), 32'd0);
    issue(6'd0, 5'd31);
    chk("full_ignored", 32'(rob_count), 32'd8);
    cdb(3'd0, 32'hA0);
    cdb(3'd1, 32'hA1);
    cdb(3'd2, 32'hA2);
    idle(8);
    chk("partial_count", 32'(rob_count), 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_tag", 32'(issue_tag), 32'(i));
      issue(6'd9, 5'(20 + i));
    end
    chk("wrap_count", 32'(rob_count), 32'd8);
    for (int i = 3; i < 11; i++) cdb(3'(i % 8), 32'(i * 3));
    idle(20);
    chk("drain_count", 32'(rob_count), 32'd0);

    // mixed types: sw and bne retire silently, addi writes once
    flush = 1'b1; cyc(); clr_in();
    s0 = strobes;
    issue(6'd7, 5'd9);
    issue(6'd8, 5'd10);
    issue(6'd1, 5'd7);
    cdb(3'd0, 32'h1);
    cdb(3'd1, 32'h2);
    cdb(3'd2, 32'h77);
    idle(6);
    chk("mixed_strobes", 32'(strobes - s0), 32'd1);
    chk("mixed_index", 32'(last_windex), 32'd7);
    chk("mixed_data", last_wdata, 32'h77);

    // duplicate CDB keeps the first value
    flush = 1'b1; cyc(); clr_in();
    issue(6'd0, 5'd4);
    cdb(3'd0, 32'h11);
    cdb(3'd0, 32'h22);
    idle(5);
    chk("dup_data", last_wdata, 32'h11);

    // CDB to an unallocated tag
    cdb(3'd5, 32'hDEAD);
    idle(3);
    chk("stray_count", 32'(rob_count), 32'd0);

    // flush while the write is being set up
    s0 = strobes;
    issue(6'd0, 5'd6);
    cdb(3'd1, 32'h66);
    cyc();
    flush = 1'b1; cyc(); clr_in();
    idle(4);
    chk("flush_strobes", 32'(strobes - s0), 32'd0);
    chk("flush_count", 32'(rob_count), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_op    = 6'($urandom_range(0, 9));
      issue_dest  = 5'($urandom);
      cdb_valid   = ($urandom_range(0, 1) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_tag = 3'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        cdb_tag = 3'($urandom);
      cdb_data = $urandom;
      flush    = ($urandom_range(0, 63) == 0);
      cyc();
    end
    clr_in();
    flush = 1'b1; cyc(); clr_in();

    // asynchronous reset in the middle of a strobe
    issue(6'd0, 5'd12);
    cdb(3'd0, 32'hBEEF);
    guard = 0;
    while (!m_we && guard < 10) begin cyc(); guard++; end
    chk("strobe_reached", 32'(rob_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", 32'(rob_we), 32'd0);
    chk("async_wdata", rob_wdata, 32'd0);
    chk("async_windex", 32'(rob_windex), 32'd0);
    chk("async_count", 32'(rob_count), 32'd0);
    model_reset();
    #10 rst_n = 1'b1;
    s0 = strobes;
    idle(5);
    chk("post_reset_strobes", 32'(strobes - s0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
